// File: rtl/exec_sequencer_if.sv
// Instruction handshake, register-file access and status signals of exec_sequencer.
// The slave modport is the sequencer; the master modport is the surrounding CPU / register file.
interface exec_sequencer_if #(
    parameter int unsigned REG_WIDTH = 16
);
    logic                 instr_valid;
    logic [15:0]          instr;
    logic                 instr_ready;
    logic [2:0]           read_1_addr;
    logic [2:0]           read_2_addr;
    logic [REG_WIDTH-1:0] read_bus_1;
    logic [REG_WIDTH-1:0] read_bus_2;
    logic [2:0]           write_addr;
    logic [REG_WIDTH-1:0] write_bus;
    logic                 write_enabled;
    logic                 done;
    logic                 illegal;
    logic                 flag_z;
    logic                 flag_c;
    logic                 flag_n;

    modport slave (
        input  instr_valid, instr, read_bus_1, read_bus_2,
        output instr_ready, read_1_addr, read_2_addr, write_addr, write_bus, write_enabled,
        output done, illegal, flag_z, flag_c, flag_n
    );

    modport master (
        output instr_valid, instr, read_bus_1, read_bus_2,
        input  instr_ready, read_1_addr, read_2_addr, write_addr, write_bus, write_enabled,
        input  done, illegal, flag_z, flag_c, flag_n
    );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle execute/writeback controller: IDLE -> DECODE -> EXECUTE -> WB, one instruction
// per four cycles, reading two registers and writing one back into the 8-entry register file.
module exec_sequencer #(
    parameter int unsigned REG_WIDTH = 16
) (
    input logic              clk,
    input logic              reset,
    exec_sequencer_if.slave  bus
);
    localparam int unsigned ShW = $clog2(REG_WIDTH);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StDecode  = 2'd1;
    localparam logic [1:0] StExecute = 2'd2;
    localparam logic [1:0] StWb      = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [15:0]          instr_q;
    logic [REG_WIDTH-1:0] op_a_q, op_b_q;
    logic [2:0]           wr_addr_q;
    logic [REG_WIDTH-1:0] wr_data_q;
    logic                 wr_en_q, done_q, illegal_q;
    logic                 z_q, c_q, n_q;

    logic [3:0]           op;
    logic [REG_WIDTH-1:0] imm6, imm9, add_b;
    logic [REG_WIDTH:0]   sum, diff;
    logic [ShW-1:0]       shamt;
    logic [REG_WIDTH-1:0] alu_res;
    logic                 alu_c, alu_wr, alu_flag, alu_ill;

    assign op    = instr_q[15:12];
    assign imm6  = {{(REG_WIDTH-6){instr_q[5]}}, instr_q[5:0]};
    assign imm9  = {{(REG_WIDTH-9){instr_q[8]}}, instr_q[8:0]};
    assign add_b = (op == 4'h8) ? imm6 : op_b_q;
    assign sum   = {1'b0, op_a_q} + {1'b0, add_b};
    // Top bit of the widened difference is the unsigned borrow.
    assign diff  = {1'b0, op_a_q} - {1'b0, op_b_q};
    assign shamt = op_b_q[ShW-1:0];

    // ALU: result, carry and which side effects the latched opcode has
    always_comb begin
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_wr   = 1'b0;
        alu_flag = 1'b0;
        alu_ill  = 1'b0;
        case (op)
            4'h0: ;
            4'h1, 4'h8: begin
                alu_res = sum[REG_WIDTH-1:0]; alu_c = sum[REG_WIDTH];
                alu_wr = 1'b1; alu_flag = 1'b1;
            end
            4'h2: begin
                alu_res = diff[REG_WIDTH-1:0]; alu_c = diff[REG_WIDTH];
                alu_wr = 1'b1; alu_flag = 1'b1;
            end
            4'h3: begin alu_res = op_a_q & op_b_q;  alu_wr = 1'b1; alu_flag = 1'b1; end
            4'h4: begin alu_res = op_a_q | op_b_q;  alu_wr = 1'b1; alu_flag = 1'b1; end
            4'h5: begin alu_res = op_a_q ^ op_b_q;  alu_wr = 1'b1; alu_flag = 1'b1; end
            4'h6: begin alu_res = op_a_q;           alu_wr = 1'b1; end
            4'h7: begin alu_res = imm9;             alu_wr = 1'b1; end
            4'h9: begin alu_res = op_a_q << shamt;  alu_wr = 1'b1; alu_flag = 1'b1; end
            4'hA: begin alu_res = op_a_q >> shamt;  alu_wr = 1'b1; alu_flag = 1'b1; end
            default: alu_ill = 1'b1;
        endcase
    end

    // Fixed four-state walk; only IDLE waits on the handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (bus.instr_valid) state_d = StDecode;
            StDecode:  state_d = StExecute;
            StExecute: state_d = StWb;
            default:   state_d = StIdle;
        endcase
    end

    // State, latched instruction/operands, registered write port and flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            instr_q   <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            n_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= (state_q == StExecute) && alu_wr;
            done_q    <= (state_q == StExecute);
            illegal_q <= (state_q == StExecute) && alu_ill;
            if (state_q == StIdle && bus.instr_valid) instr_q <= bus.instr;
            if (state_q == StDecode) begin
                op_a_q <= bus.read_bus_1;
                op_b_q <= bus.read_bus_2;
            end
            // Write address/data only move for writing ops so they hold otherwise.
            if (state_q == StExecute && alu_wr) begin
                wr_addr_q <= instr_q[11:9];
                wr_data_q <= alu_res;
            end
            if (state_q == StExecute && alu_flag) begin
                z_q <= (alu_res == '0);
                c_q <= alu_c;
                n_q <= alu_res[REG_WIDTH-1];
            end
        end
    end

    assign bus.instr_ready   = (state_q == StIdle);
    assign bus.read_1_addr   = instr_q[8:6];
    assign bus.read_2_addr   = instr_q[5:3];
    assign bus.write_addr    = wr_addr_q;
    assign bus.write_bus     = wr_data_q;
    assign bus.write_enabled = wr_en_q;
    assign bus.done          = done_q;
    assign bus.illegal       = illegal_q;
    assign bus.flag_z        = z_q;
    assign bus.flag_c        = c_q;
    assign bus.flag_n        = n_q;
endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: directed instructions push hand-computed results,
// a negedge monitor pops and compares whenever done pulses.
module tb_exec_sequencer;
    logic clk = 1'b0;
    logic reset;
    logic rf_clr;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    exec_sequencer_if #(.REG_WIDTH(16)) vif ();

    exec_sequencer #(.REG_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif)
    );

    // Register file model
    logic [15:0] rf [8];
    assign vif.read_bus_1 = rf[vif.read_1_addr];
    assign vif.read_bus_2 = rf[vif.read_2_addr];
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0;
        end else if (vif.write_enabled) begin
            rf[vif.write_addr] <= vif.write_bus;
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        ill;
        logic [2:0]  zcn;
        logic [2:0]  r1;
        logic [2:0]  r2;
    } exp_t;

    exp_t sb [$];
    int   acc_q [$];
    exp_t mon_e;
    int   mon_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    function automatic void expect_wb(input logic [15:0] ins, input logic we, input logic [2:0] wa,
                                      input logic [15:0] wd, input logic ill, input logic [2:0] zcn);
        exp_t e;
        e.we = we; e.wa = wa; e.wd = wd; e.ill = ill; e.zcn = zcn;
        e.r1 = ins[8:6]; e.r2 = ins[5:3];
        sb.push_back(e);
    endfunction

    // Handshake one instruction, then check the read addresses during DECODE.
    task automatic issue(input logic [15:0] ins, input bit track);
        int k = 0;
        @(negedge clk);
        vif.instr_valid = 1'b1;
        vif.instr       = ins;
        while (!vif.instr_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) timeout("accept");
        if (track) acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1 vif.instr_valid = 1'b0;
        @(negedge clk);
        chk("decode_rd1", vif.read_1_addr, ins[8:6]);
        chk("decode_rd2", vif.read_2_addr, ins[5:3]);
    endtask

    // Monitor: every WB cycle is compared against the oldest scoreboard entry
    always @(negedge clk) begin
        if (!reset) begin
            if (vif.write_enabled && !vif.done) chk("we_without_done", 1, 0);
            if (vif.illegal && !vif.done) chk("illegal_without_done", 1, 0);
            if (vif.done) begin
                if (sb.size() == 0 || acc_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e   = sb.pop_front();
                    mon_acc = acc_q.pop_front();
                    chk("latency", cyc - mon_acc, 2);
                    chk("write_enabled", vif.write_enabled, mon_e.we);
                    if (mon_e.we) begin
                        chk("write_addr", vif.write_addr, mon_e.wa);
                        chk("write_bus", vif.write_bus, mon_e.wd);
                    end
                    chk("illegal", vif.illegal, mon_e.ill);
                    chk("flags_zcn", {vif.flag_z, vif.flag_c, vif.flag_n}, mon_e.zcn);
                    chk("wb_rd1", vif.read_1_addr, mon_e.r1);
                    chk("wb_rd2", vif.read_2_addr, mon_e.r2);
                    chk("wb_ready", vif.instr_ready, 0);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, vif.instr_ready, 1);
        chk({tag, "_we"}, vif.write_enabled, 0);
        chk({tag, "_done_ill"}, {vif.done, vif.illegal}, 0);
        chk({tag, "_flags"}, {vif.flag_z, vif.flag_c, vif.flag_n}, 0);
        chk({tag, "_raddr"}, {vif.read_1_addr, vif.read_2_addr}, 0);
        chk({tag, "_wport"}, {vif.write_addr, vif.write_bus}, 0);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!vif.instr_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) timeout("idle");
    endtask

    int acc_idx [$];

    initial begin
        reset = 1'b1;
        rf_clr = 1'b1;
        vif.instr_valid = 1'b0;
        vif.instr = 16'h0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        rf_clr = 1'b0;

        // Directed sequence: instr, we, rd, data, illegal, {Z,C,N}
        expect_wb(16'h7205, 1, 3'd1, 16'h0005, 0, 3'b000); issue(16'h7205, 1);
        expect_wb(16'h75FF, 1, 3'd2, 16'hFFFF, 0, 3'b000); issue(16'h75FF, 1);
        expect_wb(16'h1650, 1, 3'd3, 16'h0004, 0, 3'b010); issue(16'h1650, 1);
        expect_wb(16'h2848, 1, 3'd4, 16'h0000, 0, 3'b100); issue(16'h2848, 1);
        expect_wb(16'h6A40, 1, 3'd5, 16'h0005, 0, 3'b100); issue(16'h6A40, 1);
        expect_wb(16'h9A48, 1, 3'd5, 16'h00A0, 0, 3'b000); issue(16'h9A48, 1);
        expect_wb(16'hAC48, 1, 3'd6, 16'h0000, 0, 3'b100); issue(16'hAC48, 1);
        expect_wb(16'h2E50, 1, 3'd7, 16'h0006, 0, 3'b010); issue(16'h2E50, 1);
        expect_wb(16'h8EBE, 1, 3'd7, 16'hFFFD, 0, 3'b011); issue(16'h8EBE, 1);
        expect_wb(16'h5888, 1, 3'd4, 16'hFFFA, 0, 3'b001); issue(16'h5888, 1);

        // Illegal opcode held valid for 10 cycles while the XOR is still in flight
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vif.instr_valid = 1'b1;
            vif.instr = 16'hF000;
            if (vif.instr_ready) begin
                acc_idx.push_back(i);
                expect_wb(16'hF000, 0, 3'd0, 16'h0000, 1, 3'b001);
                acc_q.push_back(cyc + 1);
            end
        end
        @(negedge clk);
        vif.instr_valid = 1'b0;
        chk("illegal_accepts", acc_idx.size(), 2);
        if (acc_idx.size() == 2) chk("illegal_spacing", acc_idx[1] - acc_idx[0], 4);
        wait_idle();
        chk("hold_write_port", {vif.write_addr, vif.write_bus}, {3'd4, 16'hFFFA});

        // Reset during EXECUTE of an ADD into r3 (r3 currently 0x0004)
        issue(16'h1650, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("midop");
        @(negedge clk);
        @(negedge clk);
        chk("midop_r3_kept", rf[3], 16'h0004);
        chk("midop_we", vif.write_enabled, 0);
        reset = 1'b0;

        expect_wb(16'h7205, 1, 3'd1, 16'h0005, 0, 3'b000); issue(16'h7205, 1);

        begin
            int k = 0;
            while (sb.size() != 0 && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        chk("sb_drained", sb.size(), 0);
        chk("final_r1", rf[1], 16'h0005);
        chk("final_r7", rf[7], 16'hFFFD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
